// File: rtl/seq_pkg.sv
// Shared types for the 1011-marker serial link: transmitter state encoding and marker constant.
package seq_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_MARK = 3'd1,
        ST_DATA = 3'd2,
        ST_PAR  = 3'd3,
        ST_GAP  = 3'd4
    } tx_state_t;

    localparam logic [3:0] MARKER_1011 = 4'b1011;

    // Marker bits go out MSB first, so index 0 selects marker[3].
    function automatic logic marker_bit(input logic [3:0] marker, input logic [1:0] idx);
        return marker[2'd3 - idx];
    endfunction

endpackage

// File: rtl/seq_piso.sv
// Parallel-load, shift-left register; the serial output is the MSB.
module seq_piso #(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic              shift,
    input  logic [DATA_W-1:0] din,
    output logic              msb
);

    logic [DATA_W-1:0] sr_reg;

    genvar gi;
    generate
        for (gi = 0; gi < DATA_W; gi++) begin : g_bit
            logic fill;
            if (gi == 0) begin : g_lsb
                assign fill = 1'b0;
            end else begin : g_upper
                assign fill = sr_reg[gi-1];
            end

            always_ff @(posedge clk) begin
                if (rst) begin
                    sr_reg[gi] <= 1'b0;
                end else if (load) begin
                    sr_reg[gi] <= din[gi];
                end else if (shift) begin
                    sr_reg[gi] <= fill;
                end
            end
        end
    endgenerate

    assign msb = sr_reg[DATA_W-1];

endmodule

// File: rtl/seq_frame_tx.sv
// Serial frame transmitter: marker 1011, payload MSB first, optional even parity bit
// (build with SEQ_TX_PARITY_EN), then an idle gap. All outputs are registered.
module seq_frame_tx
    import seq_pkg::*;
#(
    parameter int         DATA_W  = 8,
    parameter logic [3:0] MARKER  = MARKER_1011,
    parameter int         GAP_CYC = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load_valid,
    output logic              load_ready,
    input  logic [DATA_W-1:0] load_data,
    output logic              tx_bit,
    output logic              tx_valid,
    output logic              busy,
    output logic              frame_done,
    output logic [2:0]        prs_st
);

    // Counter sized for the payload, widened only if the marker or gap phase needs more.
    localparam int CNT_A  = $clog2(DATA_W + 1);
    localparam int CNT_B  = (GAP_CYC > 0) ? $clog2(GAP_CYC + 1) : 1;
    localparam int CNT_AB = (CNT_A > CNT_B) ? CNT_A : CNT_B;
    localparam int CNT_W  = (CNT_AB > 2) ? CNT_AB : 2;

    localparam logic [CNT_W-1:0] MARK_LAST = CNT_W'(3);
    localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(DATA_W - 1);
    localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'((GAP_CYC > 0) ? GAP_CYC - 1 : 0);

`ifdef SEQ_TX_PARITY_EN
    localparam bit FD_ON_DATA = 1'b0;
`else
    localparam bit FD_ON_DATA = 1'b1;
`endif

    tx_state_t        state_reg;
    logic [CNT_W-1:0] cnt_reg;
    logic             tx_bit_reg;
    logic             tx_valid_reg;
    logic             busy_reg;
    logic             frame_done_reg;
    logic             load_ready_reg;

    logic accept;
    logic piso_shift;
    logic piso_msb;

    assign accept     = load_valid && load_ready_reg;
    // The payload MSB is consumed on the MARK->DATA edge and on every DATA edge but the last.
    assign piso_shift = ((state_reg == ST_MARK) && (cnt_reg == MARK_LAST)) ||
                        ((state_reg == ST_DATA) && (cnt_reg != DATA_LAST));

    seq_piso #(
        .DATA_W (DATA_W)
    ) u_piso (
        .clk   (clk),
        .rst   (rst),
        .load  (accept),
        .shift (piso_shift),
        .din   (load_data),
        .msb   (piso_msb)
    );

`ifdef SEQ_TX_PARITY_EN
    logic parity_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            parity_reg <= 1'b0;
        end else if (accept) begin
            parity_reg <= ^load_data;
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg      <= ST_IDLE;
            cnt_reg        <= '0;
            tx_bit_reg     <= 1'b0;
            tx_valid_reg   <= 1'b0;
            busy_reg       <= 1'b0;
            frame_done_reg <= 1'b0;
            load_ready_reg <= 1'b1;
        end else begin
            frame_done_reg <= 1'b0;
            case (state_reg)
                ST_IDLE: begin
                    if (accept) begin
                        state_reg      <= ST_MARK;
                        cnt_reg        <= '0;
                        tx_bit_reg     <= MARKER[3];
                        tx_valid_reg   <= 1'b1;
                        busy_reg       <= 1'b1;
                        load_ready_reg <= 1'b0;
                    end
                end
                ST_MARK: begin
                    if (cnt_reg == MARK_LAST) begin
                        state_reg      <= ST_DATA;
                        cnt_reg        <= '0;
                        tx_bit_reg     <= piso_msb;
                        frame_done_reg <= FD_ON_DATA && (DATA_W == 1);
                    end else begin
                        cnt_reg    <= cnt_reg + CNT_W'(1);
                        tx_bit_reg <= marker_bit(MARKER, cnt_reg[1:0] + 2'd1);
                    end
                end
                ST_DATA: begin
                    if (cnt_reg == DATA_LAST) begin
`ifdef SEQ_TX_PARITY_EN
                        state_reg      <= ST_PAR;
                        cnt_reg        <= '0;
                        tx_bit_reg     <= parity_reg;
                        frame_done_reg <= 1'b1;
`else
                        cnt_reg      <= '0;
                        tx_bit_reg   <= 1'b0;
                        tx_valid_reg <= 1'b0;
                        if (GAP_CYC > 0) begin
                            state_reg <= ST_GAP;
                        end else begin
                            state_reg      <= ST_IDLE;
                            busy_reg       <= 1'b0;
                            load_ready_reg <= 1'b1;
                        end
`endif
                    end else begin
                        cnt_reg        <= cnt_reg + CNT_W'(1);
                        tx_bit_reg     <= piso_msb;
                        frame_done_reg <= FD_ON_DATA && ((cnt_reg + CNT_W'(1)) == DATA_LAST);
                    end
                end
`ifdef SEQ_TX_PARITY_EN
                ST_PAR: begin
                    cnt_reg      <= '0;
                    tx_bit_reg   <= 1'b0;
                    tx_valid_reg <= 1'b0;
                    if (GAP_CYC > 0) begin
                        state_reg <= ST_GAP;
                    end else begin
                        state_reg      <= ST_IDLE;
                        busy_reg       <= 1'b0;
                        load_ready_reg <= 1'b1;
                    end
                end
`endif
                ST_GAP: begin
                    if (cnt_reg == GAP_LAST) begin
                        state_reg      <= ST_IDLE;
                        cnt_reg        <= '0;
                        busy_reg       <= 1'b0;
                        load_ready_reg <= 1'b1;
                    end else begin
                        cnt_reg <= cnt_reg + CNT_W'(1);
                    end
                end
                default: begin
                    state_reg      <= ST_IDLE;
                    cnt_reg        <= '0;
                    tx_bit_reg     <= 1'b0;
                    tx_valid_reg   <= 1'b0;
                    busy_reg       <= 1'b0;
                    load_ready_reg <= 1'b1;
                end
            endcase
        end
    end

    assign load_ready = load_ready_reg;
    assign tx_bit     = tx_bit_reg;
    assign tx_valid   = tx_valid_reg;
    assign busy       = busy_reg;
    assign frame_done = frame_done_reg;
    assign prs_st     = state_reg;

endmodule

// File: tb/tb_seq_frame_tx.sv
// Self-checking bench for seq_frame_tx: vector table, corner-case sequences and a
// randomized run against a queue-based frame model.
`timescale 1ns/1ps
module tb_seq_frame_tx;

    localparam int DW  = 8;
    localparam int GAP = 2;
`ifdef SEQ_TX_PARITY_EN
    localparam int PB = 1;
`else
    localparam int PB = 0;
`endif
    localparam int FL      = 4 + DW + PB;
    localparam int SPACING = FL + GAP + 1;
    localparam logic [3:0] MK = 4'b1011;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          load_valid = 1'b0;
    logic [DW-1:0] load_data = '0;
    logic          load_ready, tx_bit, tx_valid, busy, frame_done;
    logic [2:0]    prs_st;

    always #5 clk = ~clk;

    seq_frame_tx #(
        .DATA_W  (DW),
        .MARKER  (4'b1011),
        .GAP_CYC (GAP)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .load_valid (load_valid),
        .load_ready (load_ready),
        .load_data  (load_data),
        .tx_bit     (tx_bit),
        .tx_valid   (tx_valid),
        .busy       (busy),
        .frame_done (frame_done),
        .prs_st     (prs_st)
    );

    typedef struct packed {
        logic       vld;
        logic       txb;
        logic       done;
        logic       bsy;
        logic       rdy;
        logic [2:0] st;
    } obs_t;

    typedef struct {
        logic          r;
        logic          lv;
        logic [DW-1:0] data;
        logic [4:0]    exp; // {tx_valid, tx_bit, frame_done, load_ready, busy}
    } vec_t;

    obs_t q[$];
    obs_t cur;
    int   n_cmp = 0;
    int   n_bad = 0;
    int   cyc = 0;
    int   acc_cyc[$];

    function automatic obs_t mk(input logic v, input logic b, input logic d,
                                input logic bs, input logic rd, input logic [2:0] st);
        obs_t o;
        o.vld = v; o.txb = b; o.done = d; o.bsy = bs; o.rdy = rd; o.st = st;
        return o;
    endfunction

    function automatic obs_t dut_obs();
        return mk(tx_valid, tx_bit, frame_done, busy, load_ready, prs_st);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Expected per-cycle observations for one accepted word.
    task automatic push_frame(input logic [DW-1:0] d);
        obs_t t;
        for (int i = 3; i >= 0; i--) q.push_back(mk(1'b1, MK[i], 1'b0, 1'b1, 1'b0, 3'd1));
        for (int i = DW - 1; i >= 0; i--) q.push_back(mk(1'b1, d[i], 1'b0, 1'b1, 1'b0, 3'd2));
        if (PB == 1) q.push_back(mk(1'b1, ^d, 1'b0, 1'b1, 1'b0, 3'd3));
        t = q[q.size()-1];
        t.done = 1'b1;
        q[q.size()-1] = t;
        for (int i = 0; i < GAP; i++) q.push_back(mk(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 3'd4));
    endtask

    // One clock: drive inputs, advance model at the edge, compare 1 ns later.
    task automatic step(input logic r, input logic lv, input logic [DW-1:0] d);
        logic pre_ready;
        pre_ready  = load_ready;
        rst        = r;
        load_valid = lv;
        load_data  = d;
        @(posedge clk);
        cyc++;
        if (r) begin
            q.delete();
            cur = mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 3'd0);
        end else if (cur.rdy && lv) begin
            push_frame(d);
            cur = q.pop_front();
        end else if (q.size() > 0) begin
            cur = q.pop_front();
        end else begin
            cur = mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 3'd0);
        end
        if (!r && lv && pre_ready) begin
            acc_cyc.push_back(cyc);
            $display("accept data=%02h at cycle %0d", d, cyc);
        end
        #1;
        check("model_obs", dut_obs(), cur);
    endtask

    initial begin
        vec_t        tbl[18];
        logic [11:0] fb;
        logic [3:0]  win;
        int          hits, hit_pos, nbits;
        logic        done_seen;

        cur = mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 3'd0);

        // Reset and a single 8'hA5 frame, cycle by cycle.
        fb = 12'b1011_1010_0101;
        tbl[0] = '{r: 1'b1, lv: 1'b0, data: 8'h00, exp: 5'b00010};
        tbl[1] = '{r: 1'b1, lv: 1'b1, data: 8'hFF, exp: 5'b00010};
        tbl[2] = '{r: 1'b0, lv: 1'b0, data: 8'h00, exp: 5'b00010};
        for (int i = 0; i < 12; i++) begin
            tbl[3+i].r    = 1'b0;
            tbl[3+i].lv   = (i == 0);
            tbl[3+i].data = (i == 0) ? 8'hA5 : 8'h5A;
            tbl[3+i].exp  = {1'b1, fb[11-i], (i == 11) ? 1'b1 : 1'b0, 1'b0, 1'b1};
        end
        tbl[15] = '{r: 1'b0, lv: 1'b0, data: 8'h00, exp: 5'b00001};
        tbl[16] = '{r: 1'b0, lv: 1'b0, data: 8'h00, exp: 5'b00001};
        tbl[17] = '{r: 1'b0, lv: 1'b0, data: 8'h00, exp: 5'b00010};

`ifndef SEQ_TX_PARITY_EN
        for (int i = 0; i < 18; i++) begin
            step(tbl[i].r, tbl[i].lv, tbl[i].data);
            check($sformatf("tbl_row%0d", i),
                  {27'd0, tx_valid, tx_bit, frame_done, load_ready, busy}, {27'd0, tbl[i].exp});
        end
        check("reset_prs_st", {29'd0, prs_st}, 32'd0);
`else
        step(1'b1, 1'b0, '0);
        step(1'b1, 1'b0, '0);
        step(1'b0, 1'b0, '0);
        check("reset_outputs", {28'd0, load_ready, tx_valid, busy, frame_done}, 32'b1000);
        check("reset_prs_st", {29'd0, prs_st}, 32'd0);
`endif

        // Back-to-back words with load_valid held high and load_data churning while busy.
        acc_cyc.delete();
        for (int k = 0; k <= SPACING; k++) begin
            step(1'b0, 1'b1, (k == 0) ? 8'h3C : (k == SPACING) ? 8'h0F : DW'($urandom));
        end
        check("b2b_accepts", acc_cyc.size(), 2);
        if (acc_cyc.size() == 2) check("b2b_spacing", acc_cyc[1] - acc_cyc[0], SPACING);
        for (int k = 0; k < SPACING; k++) step(1'b0, 1'b0, DW'($urandom));

        // Reset while the 6th frame bit of 8'hFF is on the line.
        step(1'b0, 1'b1, 8'hFF);
        for (int k = 0; k < 5; k++) step(1'b0, 1'b0, DW'($urandom));
        check("midframe_valid", {31'd0, tx_valid}, 32'd1);
        check("midframe_state", {29'd0, prs_st}, 32'd2);
        step(1'b1, 1'b0, '0);
        check("abort_outputs", {29'd0, tx_valid, busy, load_ready}, 32'b001);
        check("abort_state", {29'd0, prs_st}, 32'd0);
        done_seen = 1'b0;
        for (int k = 0; k < 2 * SPACING; k++) begin
            step(1'b0, 1'b0, '0);
            done_seen = done_seen | frame_done;
        end
        check("abort_no_done", {31'd0, done_seen}, 32'd0);

`ifdef SEQ_TX_PARITY_EN
        // Parity bit lands on bit 13, together with frame_done.
        for (int p = 0; p < 2; p++) begin
            step(1'b0, 1'b1, (p == 0) ? 8'h01 : 8'hA5);
            for (int k = 0; k < 12; k++) step(1'b0, 1'b0, '0);
            check($sformatf("parity_bit_%0d", p), {31'd0, tx_bit}, (p == 0) ? 32'd1 : 32'd0);
            check($sformatf("parity_done_%0d", p), {30'd0, frame_done, tx_valid}, 32'b11);
            check($sformatf("parity_state_%0d", p), {29'd0, prs_st}, 32'd3);
            for (int k = 0; k < GAP + 2; k++) step(1'b0, 1'b0, '0);
        end
`endif

        // An all-zero payload must present exactly one 1011 window, at frame bit 4.
        win = '0; hits = 0; hit_pos = 0; nbits = 0;
        step(1'b0, 1'b1, 8'h00);
        for (int k = 0; k < FL; k++) begin
            if (tx_valid) begin
                nbits++;
                win = {win[2:0], tx_bit};
                if (nbits >= 4 && win == MK) begin
                    hits++;
                    hit_pos = nbits;
                end
            end
            if (k < FL - 1) step(1'b0, 1'b0, '0);
        end
        check("det_hits", hits, 1);
        check("det_pos", hit_pos, 4);
        check("det_frame_len", nbits, FL);
        for (int k = 0; k < GAP + 2; k++) step(1'b0, 1'b0, '0);

        // Randomized traffic with occasional resets.
        for (int k = 0; k < 600; k++) begin
            step(($urandom_range(0, 63) == 0), ($urandom_range(0, 3) != 0), DW'($urandom));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
